// File: rtl/pattern_count_engine.sv
// Purpose : start/done accelerator that streams BYTE_CT bytes from data memory and
//           counts PAT_W-bit pattern matches in-byte (ctb), per byte (cto) and over the
//           whole bit string (cts). Optional pat_mask port under `PATTERN_COUNT_MASK_EN.
// Latency : start accepted at edge 0 -> done high after edge BYTE_CT+2; one byte/cycle.
// Backpressure: none; memory must return data exactly one cycle after each mem_rd cycle.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 begin a scan; honoured only in IDLE or DONE
//   base_addr, pat        string start address and pattern, latched on accepted start
//   pat_mask              (PATTERN_COUNT_MASK_EN only) per-bit compare enable, 0 = don't care
//   mem_rd, mem_addr      registered read strobe / address to data memory
//   mem_rdata             read data, valid the cycle after the mem_rd cycle
//   busy, done            scan in progress / results valid (level until next start)
//   ctb, cto, cts         saturating result counters

module pattern_count_engine #(
  parameter int PAT_W   = 5,
  parameter int BYTE_CT = 32,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [PAT_W-1:0]  pat,
`ifdef PATTERN_COUNT_MASK_EN
  input  logic [PAT_W-1:0]  pat_mask,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  ctb,
  output logic [CNT_W-1:0]  cto,
  output logic [CNT_W-1:0]  cts
);

  // index only needs to reach BYTE_CT-1; keep at least one bit for BYTE_CT = 1
  localparam int IDX_W = (BYTE_CT > 1) ? $clog2(BYTE_CT) : 1;
  // bits of the previous byte that can still take part in a crossing window
  localparam int HW    = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_CT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] base_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  mask_q;
  logic [HW-1:0]     hist;
  logic              first_q;   // next processed byte is string byte 0
  logic              dv;        // mem_rdata holds a requested byte this cycle

  logic              issue;
  logic              accept;

  logic [8+HW-1:0]   ext;
  logic [3:0]        ctb_inc;
  logic [3:0]        cts_inc;
  logic              any_hit;

  // Saturating add: any carry into the extra top bits means the result overflowed.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W+3:0] s;
    s = {4'b0000, a} + {{CNT_W{1'b0}}, b};
    if (s[CNT_W+3:CNT_W] != 4'b0000) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The final byte is in flight while mem_rd is still high; leave once it
        // has been returned and no further read is outstanding.
        if (dv && !mem_rd) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    issue  = 1'b0;
    accept = 1'b0;
    case (state)
      S_IDLE:  accept = start;
      S_FETCH: begin
        busy  = 1'b1;
        issue = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        done   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- match evaluation
  // ext places the tail of the previous byte above the current byte so that
  // ext[j +: PAT_W] is the window whose newest (last) string bit is byte bit j.
  assign ext = {hist, mem_rdata};

  always_comb begin
    ctb_inc = 4'd0;
    cts_inc = 4'd0;
    for (int k = 0; k <= 8 - PAT_W; k++) begin
      if (((mem_rdata[k +: PAT_W] ^ pat_q) & mask_q) == '0) begin
        ctb_inc = ctb_inc + 4'd1;
      end
    end
    for (int j = 0; j < 8; j++) begin
      // In byte 0 only windows fully inside the byte have PAT_W bits of history.
      if ((!first_q || (j <= 8 - PAT_W)) &&
          (((ext[j +: PAT_W] ^ pat_q) & mask_q) == '0)) begin
        cts_inc = cts_inc + 4'd1;
      end
    end
    any_hit = (ctb_inc != 4'd0);
  end

  // ---------------------------------------------------------------- datapath
`ifdef PATTERN_COUNT_MASK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
    end else if (accept) begin
      mask_q <= pat_mask;
    end
  end
`else
  assign mask_q = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      dv       <= 1'b0;
      idx      <= '0;
      base_q   <= '0;
      pat_q    <= '0;
      hist     <= '0;
      first_q  <= 1'b0;
      ctb      <= '0;
      cto      <= '0;
      cts      <= '0;
    end else begin
      mem_rd <= issue;
      dv     <= mem_rd;
      if (issue) begin
        mem_addr <= base_q + ADDR_W'(idx);
      end
      if (accept) begin
        // The read pipeline is always empty in IDLE/DONE, so no byte is lost here.
        base_q  <= base_addr;
        pat_q   <= pat;
        idx     <= '0;
        hist    <= '0;
        first_q <= 1'b1;
        ctb     <= '0;
        cto     <= '0;
        cts     <= '0;
      end else begin
        if (issue) begin
          idx <= idx + IDX_W'(1);
        end
        if (dv) begin
          ctb     <= sat_add(ctb, ctb_inc);
          cto     <= sat_add(cto, {3'b000, any_hit});
          cts     <= sat_add(cts, cts_inc);
          hist    <= mem_rdata[HW-1:0];
          first_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
module tb_pattern_count_engine;

  localparam int PAT_W   = 5;
  localparam int BYTE_CT = 32;
  localparam int SAT_CT  = 40;
  localparam int ADDR_W  = 8;
  localparam int CNT_W   = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              start_sat;
  logic [ADDR_W-1:0] base_addr;
  logic [PAT_W-1:0]  pat;
`ifdef PATTERN_COUNT_MASK_EN
  logic [PAT_W-1:0]  pat_mask;
`endif

  logic              mem_rd,    sat_mem_rd;
  logic [ADDR_W-1:0] mem_addr,  sat_mem_addr;
  logic [7:0]        mem_rdata, sat_mem_rdata;
  logic              busy, done, sat_busy, sat_done;
  logic [CNT_W-1:0]  ctb, cto, cts;
  logic [CNT_W-1:0]  sat_ctb, sat_cto, sat_cts;

  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int ctb;
    int cto;
    int cts;
    int t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;

  pattern_count_engine #(
    .PAT_W(PAT_W), .BYTE_CT(BYTE_CT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .pat       (pat),
`ifdef PATTERN_COUNT_MASK_EN
    .pat_mask  (pat_mask),
`endif
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .ctb       (ctb),
    .cto       (cto),
    .cts       (cts)
  );

  // Longer string so the whole-string counter runs into saturation.
  pattern_count_engine #(
    .PAT_W(PAT_W), .BYTE_CT(SAT_CT), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .start     (start_sat),
    .base_addr (base_addr),
    .pat       (pat),
`ifdef PATTERN_COUNT_MASK_EN
    .pat_mask  (pat_mask),
`endif
    .mem_rd    (sat_mem_rd),
    .mem_addr  (sat_mem_addr),
    .mem_rdata (sat_mem_rdata),
    .busy      (sat_busy),
    .done      (sat_done),
    .ctb       (sat_ctb),
    .cto       (sat_cto),
    .cts       (sat_cts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd)     mem_rdata     <= mem[mem_addr];
    if (sat_mem_rd) sat_mem_rdata <= mem[sat_mem_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising done retires the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !mon_prev) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: done rose with no scan expected (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("ctb",     ctb, mon_e.ctb);
          chk("cto",     cto, mon_e.cto);
          chk("cts",     cts, mon_e.cts);
          chk("latency", cyc - mon_e.t0 - 1, BYTE_CT + 2);
        end
      end
      mon_prev = done;
    end
  end

  task automatic fill(input logic [7:0] b, input logic [7:0] v);
    for (int i = 0; i < BYTE_CT; i++) mem[8'(int'(b) + i)] = v;
  endtask

  task automatic fill_all(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic launch(input logic [PAT_W-1:0] p, input logic [7:0] b,
                        input int e_ctb, input int e_cto, input int e_cts,
                        input bit push, input bit with_sat);
    exp_t e;
    @(negedge clk);
    pat       = p;
    base_addr = b;
    start     = 1'b1;
    start_sat = with_sat;
    if (push) begin
      e.ctb = e_ctb;
      e.cto = e_cto;
      e.cts = e_cts;
      e.t0  = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    start_sat = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    chk("ctb_cleared", ctb, 0);
    chk("cto_cleared", cto, 0);
    chk("cts_cleared", cts, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: done timeout after %0d cycles, expected done high", name, n);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    start_sat = 1'b0;
    base_addr = '0;
    pat       = '0;
`ifdef PATTERN_COUNT_MASK_EN
    pat_mask  = '1;
`endif
    fill_all(8'h00);

    #6;
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_mem_rd",   mem_rd,   0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ctb",      ctb,      0);
    chk("rst_cto",      cto,      0);
    chk("rst_cts",      cts,      0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All zeros, pattern 00000; the long instance saturates cts.
    launch(5'b00000, 8'h00, 128, 32, 252, 1'b1, 1'b1);
    wait_done("zeros");
    n = 0;
    while (!sat_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done", sat_done, 1);
    chk("sat_ctb",  sat_ctb,  160);
    chk("sat_cto",  sat_cto,  40);
    chk("sat_cts",  sat_cts,  255);

    // Alternating bits.
    fill(8'h20, 8'h55);
    launch(5'b10101, 8'h20, 64, 32, 126, 1'b1, 1'b0);
    wait_done("alt55");

    // Only byte-crossing matches; string wraps past address 0xFF.
    fill_all(8'h00);
    mem[8'hF0] = 8'h0F;
    mem[8'hF1] = 8'hF0;
    launch(5'b11111, 8'hF0, 0, 0, 4, 1'b1, 1'b0);
    wait_done("crossing");

    // Back-to-back scans from DONE; second must clear and recount.
    fill(8'h40, 8'h00);
    launch(5'b11111, 8'h40, 0, 0, 0, 1'b1, 1'b0);
    wait_done("ones_on_zero");
    fill(8'h40, 8'hFF);
    launch(5'b11111, 8'h40, 128, 32, 252, 1'b1, 1'b0);
    wait_done("ones_on_ff");

    // Reset mid-scan abandons the scan immediately.
    fill(8'h00, 8'h55);
    launch(5'b10101, 8'h00, 0, 0, 0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy",     busy,     0);
    chk("abort_done",     done,     0);
    chk("abort_mem_rd",   mem_rd,   0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_ctb",      ctb,      0);
    chk("abort_cto",      cto,      0);
    chk("abort_cts",      cts,      0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // start during FETCH with a different pattern must be ignored.
    launch(5'b10101, 8'h00, 64, 32, 126, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    pat   = 5'b00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", busy, 1);
    wait_done("ignored_start");

`ifdef PATTERN_COUNT_MASK_EN
    fill(8'h00, 8'h5A);
    pat_mask = 5'b00000;
    launch(5'b10110, 8'h00, 128, 32, 252, 1'b1, 1'b0);
    wait_done("mask_none");
    fill(8'h00, 8'h11);
    pat_mask = 5'b10001;
    launch(5'b10001, 8'h00, 32, 32, 63, 1'b1, 1'b0);
    wait_done("mask_ends");
    pat_mask = '1;
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
